// File: rtl/vga_framebuf.sv
// vga_framebuf: single-clock byte-organised pixel framebuffer.
// A CPU store port writes bytes/halves/words with per-lane bounds checks,
// a two-stage pipelined read port returns one pixel per cycle, and a clear
// engine fills the whole buffer with a byte value.

package vga_pkg;
  typedef struct packed {
    logic       memWrite;
    logic [1:0] size;      // 00 byte, 01 half, 10 word, 11 none
  } mem_ctrl_t;
endpackage

module vga_framebuf
  import vga_pkg::*;
#(
  parameter int WIDTH_PX  = 160,
  parameter int HEIGHT_PX = 120,
  parameter int BPP       = 4,
  parameter int ROW_SHIFT = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [31:0]                  i_pxlAddr,
  input  logic [31:0]                  i_pxlData,
  input  mem_ctrl_t                    i_ctrlVGA,
  input  logic                         i_clrReq,
  input  logic [7:0]                   i_clrVal,
  output logic                         o_clrBusy,
  output logic                         o_wrDrop,
  input  logic                         i_rdEn,
  input  logic [$clog2(WIDTH_PX)-1:0]  i_pxlX,
  input  logic [$clog2(HEIGHT_PX)-1:0] i_pxlY,
  output logic [BPP-1:0]               o_value,
  output logic                         o_valid
);

  localparam int ROW_BYTES = WIDTH_PX * BPP / 8;
  localparam int DEPTH     = ROW_BYTES * HEIGHT_PX;
  localparam int PPB       = 8 / BPP;
  localparam int AW        = $clog2(DEPTH);
  localparam int SW        = (PPB > 1) ? $clog2(PPB) : 1;

  // Clear engine states; o_clrBusy is the externally visible state bit.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  generate
    if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bad_bpp
      $error("vga_framebuf: BPP must be 1, 2, 4 or 8");
    end
    if ((WIDTH_PX * BPP) % 8 != 0) begin : g_bad_width
      $error("vga_framebuf: WIDTH_PX*BPP must be a multiple of 8");
    end
  endgenerate

  logic [7:0]    mem [DEPTH];

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [7:0]    clr_val;

  logic          store_req;
  logic          store_ok;
  logic [3:0]    lane_en;
  logic [AW-1:0] lane_addr [4];
  logic [7:0]    lane_data [4];

  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_sub;
  logic [7:0]    rd_byte;
  logic          s1_valid;
  logic          s1_in_range;
  logic [SW-1:0] s1_sub;
  logic [BPP-1:0] rd_pix;

  // Address bits above the row field carry no meaning for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_pxlAddr[31:ROW_SHIFT+8];

  assign o_clrBusy = (state == ST_CLEAR);
  assign store_req = i_ctrlVGA.memWrite && (i_ctrlVGA.size != 2'b11);
  assign store_ok  = store_req && !o_clrBusy;

  // Store decode: align the column by truncation, then enable each byte lane
  // only when its row and column both fall inside the image.
  always_comb begin
    int row_i;
    int col_i;
    int n_lanes;
    row_i = int'(i_pxlAddr[ROW_SHIFT+7:ROW_SHIFT]);
    col_i = int'(i_pxlAddr[ROW_SHIFT-1:0]);
    case (i_ctrlVGA.size)
      2'b00:   n_lanes = 1;
      2'b01:   begin n_lanes = 2; col_i = (col_i / 2) * 2; end
      2'b10:   begin n_lanes = 4; col_i = (col_i / 4) * 4; end
      default: n_lanes = 0;
    endcase
    for (int k = 0; k < 4; k++) begin
      lane_en[k]   = store_ok && (k < n_lanes) && (row_i < HEIGHT_PX) &&
                     ((col_i + k) < ROW_BYTES);
      lane_addr[k] = AW'(row_i * ROW_BYTES + col_i + k);
      lane_data[k] = i_pxlData[8*k +: 8];
    end
  end

  // Pixel address: linear pixel index split into byte address and sub-pixel slot.
  always_comb begin
    int p;
    rd_in_range = (int'(i_pxlY) < HEIGHT_PX) && (int'(i_pxlX) < WIDTH_PX);
    p           = int'(i_pxlY) * WIDTH_PX + int'(i_pxlX);
    rd_addr     = rd_in_range ? AW'(p / PPB) : '0;
    rd_sub      = SW'(p % PPB);
  end

  // Clear engine: latch the fill byte on request, then sweep every byte once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      clr_val <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_clrReq) begin
            clr_val <= i_clrVal;
            clr_cnt <= '0;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage: the clear owns the write port while busy; the read is read-first.
  always_ff @(posedge i_clk) begin
    if (o_clrBusy) begin
      mem[clr_cnt] <= clr_val;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem[lane_addr[k]] <= lane_data[k];
        end
      end
    end
    if (i_rdEn) begin
      rd_byte <= mem[rd_addr];
    end
  end

  // Read stage 1 side-band: sub-pixel slot and range flag travel with the RAM byte.
  // Read handshake: i_rdEn is a request with no backpressure; o_valid marks the
  // result of the request issued exactly two cycles earlier, one per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_sub      <= '0;
    end else begin
      s1_valid <= i_rdEn;
      if (i_rdEn) begin
        s1_in_range <= rd_in_range;
        s1_sub      <= rd_sub;
      end
    end
  end

  assign rd_pix = BPP'(rd_byte >> (int'(s1_sub) * BPP));

  // Read stage 2: select the pixel; out-of-range reads return 0, idle holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_value <= '0;
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_value <= s1_in_range ? rd_pix : '0;
      end
    end
  end

  // Drop flag: one-cycle pulse for a real store that arrived during a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wrDrop <= 1'b0;
    end else begin
      o_wrDrop <= store_req && o_clrBusy;
    end
  end

endmodule

// File: tb/tb_vga_framebuf.sv
// tb_vga_framebuf: randomized and directed checks of vga_framebuf against a
// byte-array reference model of the image (default 160x120x4 instance) plus a
// small directed check of a 640x480x1 instance.

module tb_vga_framebuf;
  import vga_pkg::*;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int BPP   = 4;
  localparam int RB    = W * BPP / 8;
  localparam int DEPTH = RB * H;
  localparam int PPB   = 8 / BPP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (default geometry) ----------------
  logic [31:0] pxl_addr, pxl_data;
  mem_ctrl_t   ctrl;
  logic        clr_req, clr_busy, wr_drop, rd_en, valid;
  logic [7:0]  clr_val;
  logic [7:0]  pxl_x;
  logic [6:0]  pxl_y;
  logic [3:0]  value;

  vga_framebuf dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pxlAddr(pxl_addr), .i_pxlData(pxl_data), .i_ctrlVGA(ctrl),
    .i_clrReq(clr_req), .i_clrVal(clr_val),
    .o_clrBusy(clr_busy), .o_wrDrop(wr_drop),
    .i_rdEn(rd_en), .i_pxlX(pxl_x), .i_pxlY(pxl_y),
    .o_value(value), .o_valid(valid)
  );

  // ---------------- DUT1 (640x480, 1 bpp) ----------------
  logic [31:0] pxl_addr1, pxl_data1;
  mem_ctrl_t   ctrl1;
  logic        clr_req1, clr_busy1, wr_drop1, rd_en1, valid1;
  logic [7:0]  clr_val1;
  logic [9:0]  pxl_x1;
  logic [8:0]  pxl_y1;
  logic [0:0]  value1;

  vga_framebuf #(.WIDTH_PX(640), .HEIGHT_PX(480), .BPP(1), .ROW_SHIFT(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pxlAddr(pxl_addr1), .i_pxlData(pxl_data1), .i_ctrlVGA(ctrl1),
    .i_clrReq(clr_req1), .i_clrVal(clr_val1),
    .o_clrBusy(clr_busy1), .o_wrDrop(wr_drop1),
    .i_rdEn(rd_en1), .i_pxlX(pxl_x1), .i_pxlY(pxl_y1),
    .o_value(value1), .o_valid(valid1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mdl [DEPTH];

  function automatic logic [3:0] model_pixel(input int x, input int y);
    int p;
    logic [7:0] b;
    if (x >= W || y >= H) return 4'h0;
    p = y * W + x;
    b = mdl[p / PPB];
    return 4'(b >> ((p % PPB) * BPP));
  endfunction

  task automatic model_store(input int row, input int col, input logic [1:0] sz,
                             input logic [31:0] d);
    int n, base;
    if (sz == 2'b11) return;
    n    = 1 << sz;
    base = col - (col % n);
    for (int k = 0; k < n; k++) begin
      if (row < H && (base + k) < RB) mdl[row * RB + base + k] = d[8*k +: 8];
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         due_q[$];
  logic [3:0] last_exp = 4'h0;

  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("rd_valid", 32'(valid), 32'(1));
      chk("rd_value", 32'(value), 32'(exp_q[0]));
      last_exp = exp_q[0];
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else if (valid) begin
      chk("rd_unexpected_valid", 32'(valid), 32'(0));
    end
  end

  // ---------------- drivers ----------------
  task automatic set_idle();
    rd_en = 1'b0; ctrl = '{memWrite: 1'b0, size: 2'b11};
    clr_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_idle();
    end
  endtask

  // One cycle of optional read and optional store; the read sees pre-store data.
  task automatic drive_cycle(input bit rd, input int x, input int y,
                             input bit wr, input logic [1:0] sz,
                             input int row, input int col, input logic [31:0] d);
    @(posedge clk); #1;
    set_idle();
    rd_en    = rd;
    pxl_x    = 8'(x);
    pxl_y    = 7'(y);
    ctrl     = '{memWrite: wr, size: sz};
    pxl_addr = {16'($urandom), 8'(row), 8'(col)};
    pxl_data = d;
    if (rd) begin
      exp_q.push_back(model_pixel(int'(pxl_x), int'(pxl_y)));
      due_q.push_back(cyc + 2);
    end
    if (wr) model_store(row, col, sz, d);
  endtask

  task automatic rd(input int x, input int y);
    drive_cycle(1'b1, x, y, 1'b0, 2'b11, 0, 0, 32'h0);
  endtask

  task automatic st(input logic [1:0] sz, input int row, input int col, input logic [31:0] d);
    drive_cycle(1'b0, 0, 0, 1'b1, sz, row, col, d);
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'($urandom), $urandom_range(0, 170), $urandom_range(0, 127),
                  1'($urandom), 2'($urandom), $urandom_range(0, 123),
                  $urandom_range(0, 85), $urandom);
    end
    idle(4);
  endtask

  // Full clear; with traffic, also a same-cycle store, a store, a re-request
  // and a size-11 store during the clear.
  task automatic run_clear(input logic [7:0] v, input bit traffic);
    int busy_n;
    @(posedge clk); #1;
    set_idle();
    clr_req = 1'b1;
    clr_val = v;
    if (traffic) begin
      ctrl = '{memWrite: 1'b1, size: 2'b10};
      pxl_addr = {16'h0, 8'd5, 8'd0};
      pxl_data = 32'h1234_5678;
    end
    busy_n = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      @(posedge clk); #1;
      set_idle();
      clr_val = 8'($urandom);
      if (traffic && i == 10) begin
        ctrl = '{memWrite: 1'b1, size: 2'b10};
        pxl_addr = 32'h0;
        pxl_data = 32'hdead_beef;
      end
      if (traffic && i == 20) begin clr_req = 1'b1; clr_val = 8'h55; end
      if (traffic && i == 30) ctrl = '{memWrite: 1'b1, size: 2'b11};
      if (traffic && i == 40) ctrl = '{memWrite: 1'b0, size: 2'b00};
      @(negedge clk);
      if (clr_busy) busy_n++;
      if (traffic && (i == 0 || i == 11 || i == 12 || i == 31 || i == 41))
        chk($sformatf("wr_drop_i%0d", i), 32'(wr_drop), 32'(i == 11));
      if (!clr_busy) break;
    end
    chk("clr_busy_len", 32'(busy_n), 32'(DEPTH));
    for (int b = 0; b < DEPTH; b++) mdl[b] = v;
  endtask

  // 1-bpp instance: single isolated read, checked two edges later.
  task automatic rd1(input int x, input logic [7:0] b0);
    logic [0:0] e;
    e = (x < 8) ? 1'(b0 >> x) : 1'b0;
    @(posedge clk); #1;
    rd_en1 = 1'b1; pxl_x1 = 10'(x); pxl_y1 = 9'd0;
    @(posedge clk); #1;
    rd_en1 = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("bpp1_valid_x%0d", x), 32'(valid1), 32'(1));
    chk($sformatf("bpp1_value_x%0d", x), 32'(value1), 32'(e));
    @(posedge clk); #1;
    chk("bpp1_valid_drop", 32'(valid1), 32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r;
    logic [7:0]  b0;
    rst_n = 1'b0;
    set_idle();
    clr_val = 8'h0; pxl_x = '0; pxl_y = '0; pxl_addr = '0; pxl_data = '0;
    rd_en1 = 1'b0; ctrl1 = '{memWrite: 1'b0, size: 2'b11}; clr_req1 = 1'b0;
    clr_val1 = 8'h0; pxl_x1 = '0; pxl_y1 = '0; pxl_addr1 = '0; pxl_data1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value",  32'(value),     32'(0));
    chk("rst_valid",  32'(valid),     32'(0));
    chk("rst_busy",   32'(clr_busy),  32'(0));
    chk("rst_drop",   32'(wr_drop),   32'(0));
    chk("rst1_value", 32'(value1),    32'(0));
    chk("rst1_valid", 32'(valid1),    32'(0));
    chk("rst1_busy",  32'(clr_busy1), 32'(0));
    chk("rst1_drop",  32'(wr_drop1),  32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid",  32'(valid),  32'(0));
      chk("idle_valid1", 32'(valid1), 32'(0));
    end

    // Bring the buffer to a known state
    run_clear(8'h00, 1'b0);

    // Byte store then reads of both pixels of that byte
    st(2'b00, 3, 10, 32'h0000_00A5);
    rd(20, 3);
    rd(21, 3);
    idle(4);
    chk("rd_hold", 32'(value), 32'(last_exp));

    // Row-end and out-of-range stores
    st(2'b10, 0, 78, 32'h4433_2211);
    st(2'b10, 0, 80, 32'hCAFE_F00D);
    st(2'b00, 120, 0, 32'h0000_00EE);
    st(2'b01, 2, 79, 32'h0000_BBAA);
    st(2'b00, 4, 82, 32'h0000_0077);
    for (int x = 148; x < 162; x++) rd(x, 0);
    for (int x = 0; x < 8; x++) rd(x, 1);
    for (int x = 152; x < 160; x++) rd(x, 2);
    for (int x = 0; x < 8; x++) rd(x, 5);
    rd(0, 120);
    rd(200, 7);
    idle(4);

    // Mixed random traffic (reads and stores in the same cycle included)
    random_traffic(800);

    // Clear with interference, then full readback
    run_clear(8'h3C, 1'b1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd(x, y);
    idle(4);

    // Reset in the middle of a clear
    @(posedge clk); #1;
    set_idle();
    clr_req = 1'b1; clr_val = 8'h96;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_clear_busy", 32'(clr_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(clr_busy), 32'(0));
    chk("abort_valid", 32'(valid),    32'(0));
    chk("abort_value", 32'(value),    32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 100; b++) mdl[b] = 8'h96;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++) rd(x, y);
    idle(4);
    random_traffic(300);

    // 1-bpp instance: byte 0x81 at row 0 col 0
    r  = $urandom;
    b0 = 8'h81;
    @(posedge clk); #1;
    ctrl1 = '{memWrite: 1'b1, size: 2'b00};
    pxl_addr1 = 32'h0;
    pxl_data1 = {r[31:8], b0};
    @(posedge clk); #1;
    ctrl1 = '{memWrite: 1'b0, size: 2'b11};
    for (int x = 0; x < 8; x++) rd1(x, b0);
    rd1(640, b0);

    chk("rd_drain", 32'(due_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
